shift_register: RTL and testbench
=================================

SHIFT_REGISTER -- requirements
Module: shift_register

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: en  input  1  enable; when low the register SHALL hold.
REQ-005 Port: in  input  1  serial data input.
REQ-006 Port: parallel_in  input  WIDTH  parallel load data.
REQ-007 Port: load  input  1  parallel load request.
REQ-008 Port: direction  input  1  shift direction: 0 = left (toward MSB), 1 = right (toward LSB).
REQ-009 Port: out  output  1  serial data output.
REQ-010 Port: parallel_out  output  WIDTH  current register contents.
REQ-011 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-012 The block SHALL hold one WIDTH-bit state register, driven directly onto parallel_out.
REQ-013 Update priority at each rising clk edge SHALL be: rst, then en=0 (hold), then load=1 (load), then shift.
REQ-014 With en=1 and load=1, the register SHALL take parallel_in on that edge, regardless of direction and in.
REQ-015 With en=1, load=0 and direction=0, the register SHALL become {reg[WIDTH-2:0], in}, so in enters bit 0.
REQ-016 With en=1, load=0 and direction=1, the register SHALL become {in, reg[WIDTH-1:1]}, so in enters bit WIDTH-1.
REQ-017 With en=0, the register SHALL hold its value; load, in and direction SHALL be ignored.
REQ-018 out SHALL be combinational from the register and direction: reg[WIDTH-1] when direction=0, reg[0] when direction=1.
REQ-019 Latency: a load or shift SHALL be visible on parallel_out immediately after the triggering edge, i.e. one cycle of latency.
REQ-020 After WIDTH consecutive shifts with in held constant, every bit of parallel_out SHALL equal in.
REQ-021 A change of direction between cycles SHALL take effect on the next edge, with no extra latency and no loss of state.
REQ-022 No X SHALL propagate from inputs that are ignored in the current mode.

Reset
REQ-023 While rst=1, the register SHALL be forced to all zeros immediately, without waiting for a clock edge, and SHALL stay zero on every edge while rst remains asserted.
REQ-024 While rst=1, parallel_out SHALL be 0. out SHALL also be 0.
REQ-025 Asserting rst mid-operation, including during a load cycle, SHALL discard the in-progress operation and clear the register.
REQ-026 On the first rising edge after rst deasserts, normal priority (REQ-013) SHALL apply.

Verification
REQ-027 Load: rst for 20 cycles, release, then en=1, load=1, parallel_in=random, for one edge -> parallel_out == parallel_in 1 ns after that edge.
REQ-028 Reset: preload any value, assert rst=1 with en=1, in=1, load=0, and hold for 20 edges -> parallel_out == 8'h00 throughout, including between edges.
REQ-029 Right shift: reset, then en=1, direction=1, in=1, load=0, for 20 edges -> parallel_out == 8'hFF, parallel_out[7] == 1, out == 1.
REQ-030 Left shift: reset, then en=1, direction=0, in=1, for 20 edges -> parallel_out[0] == 1, parallel_out == 8'hFF; after one edge only, parallel_out == 8'h01.
REQ-031 Hold: load 8'hA5, set en=0, toggle load/in/direction for 5 edges -> parallel_out stays 8'hA5.
REQ-032 Serial out: load 8'h81, direction=0, in=0, shift 1 edge -> parallel_out == 8'h02, out == 0; a bench SHALL check out against REQ-018 on every cycle.

Source files
------------

// File: rtl/shift_register.sv
// shift_register: WIDTH-bit serial/parallel shift register
// with enable, parallel load and selectable shift direction.
module shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load,
  input  logic             direction,
  output logic             out,
  output logic [WIDTH-1:0] parallel_out
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;

  // next value: hold, load, or shift left/right by one
  always_comb begin
    q_nxt = q;
    if (en) begin
      if (load) begin
        q_nxt = parallel_in;
      end else if (direction) begin
        q_nxt = {in, q[WIDTH-1:1]};
      end else begin
        q_nxt = {q[WIDTH-2:0], in};
      end
    end
  end

  // state register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

  assign parallel_out = q;
  assign out = direction ? q[0] : q[WIDTH-1];

endmodule

// File: tb/tb_shift_register.sv
// tb_shift_register: directed tests for shift_register
// plus a per-cycle check of out and parallel_out.
module tb_shift_register;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in;
  logic [7:0] parallel_in;
  logic       load;
  logic       direction;
  logic       out;
  logic [7:0] parallel_out;

  int checks = 0;
  int errs = 0;
  logic [7:0] m = '0;
  logic [7:0] rnd;

  shift_register #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .in(in),
    .parallel_in(parallel_in),
    .load(load),
    .direction(direction),
    .out(out),
    .parallel_out(parallel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference register tracking the expected contents
  always @(posedge clk or posedge rst) begin
    if (rst) m <= 8'h00;
    else if (en) begin
      if (load) m <= parallel_in;
      else if (direction) m <= {in, m[7:1]};
      else m <= {m[6:0], in};
    end
  end

  // every cycle: out and parallel_out against the reference
  always @(negedge clk) begin
    checks++;
    if (out !== (direction ? m[0] : m[7])) begin
      errs++;
      $display("FAIL cyc_out: got %b want %b (m=%h dir=%b)",
               out, direction ? m[0] : m[7], m, direction);
    end
    checks++;
    if (parallel_out !== m) begin
      errs++;
      $display("FAIL cyc_pout: got %h want %h",
               parallel_out, m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    en = 1'b1;
    load = 1'b1;
    parallel_in = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_load();
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b0;
    rnd = 8'($urandom);
    en = 1'b1;
    load = 1'b1;
    parallel_in = rnd;
    tick();
    checks++;
    if (parallel_out !== rnd) begin
      errs++;
      $display("FAIL load: got %h want %h", parallel_out, rnd);
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    do_load(8'h3C);
    checks++;
    if (parallel_out !== 8'h3C) begin
      errs++;
      $display("FAIL rst_pre: got %h want 3c", parallel_out);
    end
    en = 1'b1;
    in = 1'b1;
    load = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (parallel_out !== 8'h00) begin
      errs++;
      $display("FAIL rst_async: got %h want 00", parallel_out);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (parallel_out !== 8'h00 || out !== 1'b0) begin
        errs++;
        $display("FAIL rst_hold: got %h/%b want 00/0",
                 parallel_out, out);
      end
      #3;
      checks++;
      if (parallel_out !== 8'h00) begin
        errs++;
        $display("FAIL rst_mid: got %h want 00", parallel_out);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_right_shift();
    pulse_rst();
    en = 1'b1;
    direction = 1'b1;
    in = 1'b1;
    load = 1'b0;
    tick();
    checks++;
    if (parallel_out !== 8'h80) begin
      errs++;
      $display("FAIL rshift_1: got %h want 80", parallel_out);
    end
    for (int i = 0; i < 19; i++) tick();
    checks++;
    if (parallel_out !== 8'hFF || parallel_out[7] !== 1'b1 ||
        out !== 1'b1) begin
      errs++;
      $display("FAIL rshift_20: got %h/%b want ff/1",
               parallel_out, out);
    end
  endtask

  task automatic test_left_shift();
    pulse_rst();
    en = 1'b1;
    direction = 1'b0;
    in = 1'b1;
    load = 1'b0;
    tick();
    checks++;
    if (parallel_out !== 8'h01) begin
      errs++;
      $display("FAIL lshift_1: got %h want 01", parallel_out);
    end
    for (int i = 0; i < 19; i++) tick();
    checks++;
    if (parallel_out !== 8'hFF || parallel_out[0] !== 1'b1) begin
      errs++;
      $display("FAIL lshift_20: got %h want ff", parallel_out);
    end
  endtask

  task automatic test_hold();
    do_load(8'hA5);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load = ~load;
      in = ~in;
      direction = ~direction;
      parallel_in = 8'h5A ^ 8'(i);
      tick();
      checks++;
      if (parallel_out !== 8'hA5) begin
        errs++;
        $display("FAIL hold: got %h want a5", parallel_out);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_serial_out();
    direction = 1'b0;
    do_load(8'h81);
    checks++;
    if (out !== 1'b1) begin
      errs++;
      $display("FAIL sout_msb: got %b want 1", out);
    end
    en = 1'b0;
    direction = 1'b1;
    #1;
    checks++;
    if (out !== 1'b1) begin
      errs++;
      $display("FAIL sout_lsb: got %b want 1", out);
    end
    en = 1'b1;
    direction = 1'b0;
    in = 1'b0;
    tick();
    checks++;
    if (parallel_out !== 8'h02 || out !== 1'b0) begin
      errs++;
      $display("FAIL sout_shift: got %h/%b want 02/0",
               parallel_out, out);
    end
  endtask

  task automatic test_direction_change();
    logic [7:0] exp_v [4];
    logic       dir_v [4];
    logic       in_v [4];
    exp_v = '{8'h65, 8'h32, 8'h99, 8'h32};
    dir_v = '{1'b0, 1'b1, 1'b1, 1'b0};
    in_v = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_load(8'hB2);
    for (int i = 0; i < 4; i++) begin
      direction = dir_v[i];
      in = in_v[i];
      tick();
      checks++;
      if (parallel_out !== exp_v[i]) begin
        errs++;
        $display("FAIL dirchg%0d: got %h want %h",
                 i, parallel_out, exp_v[i]);
      end
    end
  endtask

  task automatic test_mid_reset_load();
    do_load(8'h5A);
    en = 1'b1;
    load = 1'b1;
    parallel_in = 8'hC3;
    rst = 1'b1;
    tick();
    checks++;
    if (parallel_out !== 8'h00) begin
      errs++;
      $display("FAIL rst_load: got %h want 00", parallel_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (parallel_out !== 8'hC3) begin
      errs++;
      $display("FAIL post_rst: got %h want c3", parallel_out);
    end
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    in = 1'b0;
    load = 1'b0;
    direction = 1'b0;
    parallel_in = 8'h00;
    test_load();
    test_reset();
    test_right_shift();
    test_left_shift();
    test_hold();
    test_serial_out();
    test_direction_change();
    test_mid_reset_load();
    tick();
    $display("test done: total=%0d bad=%0d", checks, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
